// File: rtl/hangy_pkg.sv
// Shared constants for the hangman game: state encoding, word geometry and word ROM.
package hangy_pkg;

  localparam int LETTER_W       = 5;
  localparam int WORD_LEN       = 5;
  localparam int WORD_W         = LETTER_W * WORD_LEN;
  localparam int ROM_DEPTH      = 4;
  localparam int ROM_IDX_W      = $clog2(ROM_DEPTH);
  localparam int DEF_MAX_MISSES = 6;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    GEN  = 4'd1,
    WAIT = 4'd2,
    CMP0 = 4'd3,
    HIT0 = 4'd4,
    CMP1 = 4'd5,
    HIT1 = 4'd6,
    CMP2 = 4'd7,
    HIT2 = 4'd8,
    CMP3 = 4'd9,
    HIT3 = 4'd10,
    CMP4 = 4'd11,
    HIT4 = 4'd12,
    MISS = 4'd13,
    WIN  = 4'd14,
    LOSE = 4'd15
  } state_t;

  // Position 0 of each word sits in the top letter slot (bits 24:20).
  function automatic logic [WORD_W-1:0] word_rom(input logic [ROM_IDX_W-1:0] idx);
    case (idx)
      2'd0:    word_rom = 25'b01101_01110_10011_10001_00101;
      2'd1:    word_rom = 25'b01000_00101_01100_01100_01111;
      2'd2:    word_rom = 25'b00001_10000_10000_01100_00101;
      default: word_rom = 25'b00011_10010_00001_01110_00101;
    endcase
  endfunction

endpackage

// File: rtl/hangy_controller.sv
// Game sequencer: start, guess latch, letter-by-letter compare walk, hit/miss bookkeeping.
// state | meaning: IDLE await start | GEN load word | WAIT await guess | CMPk compare slot k
//       | HITk mark slot k | MISS count miss | WIN/LOSE hold until return
module hangy_controller
  import hangy_pkg::*;
#(
  parameter int MAX_MISSES = DEF_MAX_MISSES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] chip_input,
  input  logic [4:0] match,
  input  logic [4:0] found,
  input  logic [2:0] misses,
  output logic [3:0] state_out,
  output logic       gen_word,
  output logic       latch_guess,
  output logic [4:0] set_found,
  output logic       inc_miss
);

  state_t state = IDLE;
  state_t state_next;

  logic       strobe;
  logic [4:0] code;

  assign strobe    = chip_input[5];
  assign code      = chip_input[4:0];
  assign state_out = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    gen_word    = 1'b0;
    latch_guess = 1'b0;
    set_found   = 5'b00000;
    inc_miss    = 1'b0;
    case (state)
      IDLE: if (chip_input == 6'b111111) state_next = GEN;
      GEN: begin
        gen_word   = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (strobe && code == 5'd0) begin
          state_next = IDLE;
        end else if (strobe && code >= 5'd1 && code <= 5'd26) begin
          latch_guess = 1'b1;
          state_next  = CMP0;
        end
      end
      CMP0: state_next = match[4] ? HIT0 : CMP1;
      CMP1: state_next = match[3] ? HIT1 : CMP2;
      CMP2: state_next = match[2] ? HIT2 : CMP3;
      CMP3: state_next = match[1] ? HIT3 : CMP4;
      CMP4: state_next = match[0] ? HIT4 : MISS;
      HIT0: set_found = 5'b10000;
      HIT1: set_found = 5'b01000;
      HIT2: set_found = 5'b00100;
      HIT3: set_found = 5'b00010;
      HIT4: set_found = 5'b00001;
      MISS: begin
        inc_miss   = 1'b1;
        state_next = (int'(misses) + 1 >= MAX_MISSES) ? LOSE : WAIT;
      end
      WIN, LOSE: if (strobe && code == 5'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Every HIT state resolves against the mask as it will look after this hit.
    if (set_found != 5'b00000)
      state_next = ((found | set_found) == 5'b11111) ? WIN : WAIT;
  end

endmodule

// File: rtl/hangy.sv
// Hangman top: word/found/miss datapath plus registered status output around the sequencer.
module hangy
  import hangy_pkg::*;
#(
  parameter int MAX_MISSES = DEF_MAX_MISSES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] chip_input,
  output logic [6:0] chip_output
);

  logic [WORD_W-1:0]    word;
  logic [ROM_IDX_W-1:0] word_idx = '0;
  logic [4:0]           found;
  logic [2:0]           misses;
  logic [LETTER_W-1:0]  guess;
  logic [6:0]           out_q = '0;
  logic [4:0]           match;
  logic [3:0]           cur_state;
  logic                 gen_word;
  logic                 latch_guess;
  logic [4:0]           set_found;
  logic                 inc_miss;

  assign chip_output = out_q;

  // found[i] and word[i*5 +: 5] both describe position 4-i.
  always_comb begin
    match = '0;
    for (int i = 0; i < WORD_LEN; i++)
      match[i] = (word[i*LETTER_W +: LETTER_W] == guess) && !found[i];
  end

  hangy_controller #(
    .MAX_MISSES(MAX_MISSES)
  ) controlly (
    .clk        (clk),
    .reset      (reset),
    .chip_input (chip_input),
    .match      (match),
    .found      (found),
    .misses     (misses),
    .state_out  (cur_state),
    .gen_word   (gen_word),
    .latch_guess(latch_guess),
    .set_found  (set_found),
    .inc_miss   (inc_miss)
  );

  always_ff @(posedge clk or posedge reset) begin : daty
    if (reset) begin
      word     <= '0;
      word_idx <= '0;
      found    <= '0;
      misses   <= '0;
      guess    <= '0;
      out_q    <= '0;
    end else begin
      if (gen_word) begin
        word     <= word_rom(word_idx);
        word_idx <= word_idx + 1'b1;
        found    <= '0;
        misses   <= '0;
      end else begin
        found <= found | set_found;
        if (inc_miss && misses != 3'd7) misses <= misses + 3'd1;
      end
      if (latch_guess) guess <= chip_input[LETTER_W-1:0];
      out_q <= {cur_state == LOSE, cur_state == WIN, found};
    end
  end

endmodule

// File: tb/tb_hangy.sv
// Bench for hangy: directed vector table, async reset corner, randomized games vs. a word-level model.
module tb_hangy;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] chip_input = '0;
  logic [6:0] chip_output;

  int checks = 0;
  int errors = 0;

  hangy #(.MAX_MISSES(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .chip_input (chip_input),
    .chip_output(chip_output)
  );

  always #5 clk = ~clk;

  logic [3:0] st;
  assign st = dut.controlly.state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: input held one cycle, expected states after each edge (nibbles, left-justified),
  // then chip_output after one further quiet cycle.
  typedef struct {
    logic [5:0]  din;
    int          n;
    logic [27:0] sts;
    logic [6:0]  out;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [5:0] d, input int n, input logic [27:0] s, input logic [6:0] o);
    vec_t v;
    v.din = d; v.n = n; v.sts = s; v.out = o;
    tbl.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    chip_input = v.din;
    for (int i = 0; i < v.n; i++) begin
      tick();
      chip_input = '0;
      check($sformatf("vec%0d state%0d", idx, i), 32'(st), 32'(v.sts[27-4*i -: 4]));
    end
    tick();
    check($sformatf("vec%0d out", idx), 32'(chip_output), 32'(v.out));
  endtask

  // Word-level reference model: letters per word, per-position found flags, miss tally.
  int rom_l[4][5] = '{'{13, 14, 19, 17, 5}, '{8, 5, 12, 12, 15},
                      '{1, 16, 16, 12, 5}, '{3, 18, 1, 14, 5}};
  int m_mode;
  int m_idx;
  int m_misses;
  int m_word[5];
  bit m_found[5];
  int exp_q[$];

  function automatic void model(input logic [5:0] d);
    bit s;
    int c;
    s = d[5];
    c = int'(d[4:0]);
    exp_q.delete();
    case (m_mode)
      0: begin
        if (d == 6'b111111) begin
          m_word   = rom_l[m_idx];
          m_idx    = (m_idx + 1) % 4;
          m_misses = 0;
          for (int k = 0; k < 5; k++) m_found[k] = 1'b0;
          m_mode = 2;
          exp_q.push_back(1);
        end
      end
      2: begin
        if (s && c == 0) begin
          m_mode = 0;
        end else if (s && c >= 1 && c <= 26) begin
          int p;
          int last;
          int cnt;
          p = -1;
          for (int k = 0; k < 5; k++)
            if (p < 0 && m_word[k] == c && !m_found[k]) p = k;
          last = (p < 0) ? 4 : p;
          for (int k = 0; k <= last; k++) exp_q.push_back(3 + 2 * k);
          if (p >= 0) begin
            exp_q.push_back(4 + 2 * p);
            m_found[p] = 1'b1;
            cnt = 0;
            for (int k = 0; k < 5; k++) cnt += int'(m_found[k]);
            if (cnt == 5) m_mode = 14;
          end else begin
            exp_q.push_back(13);
            if (m_misses < 7) m_misses++;
            if (m_misses >= 6) m_mode = 15;
          end
        end
      end
      default: if (s && c == 0) m_mode = 0;
    endcase
    exp_q.push_back(m_mode);
  endfunction

  function automatic logic [6:0] exp_out();
    return {m_mode == 15, m_mode == 14,
            m_found[0], m_found[1], m_found[2], m_found[3], m_found[4]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Game on ROM[0] (m n s q e): start, then hit each slot in order to a win.
    add(6'b111111, 2, 28'h1200000, 7'b0000000);
    add(6'b101101, 3, 28'h3420000, 7'b0010000);
    add(6'b101110, 4, 28'h3562000, 7'b0011000);
    add(6'b110011, 5, 28'h3578200, 7'b0011100);
    add(6'b110001, 6, 28'h3579A20, 7'b0011110);
    add(6'b100101, 7, 28'h3579BCE, 7'b0111111);
    add(6'b100000, 1, 28'h0000000, 7'b0011111);
    // ROM[1] (h e l l o): repeated letter fills lowest unfound slot, then misses.
    add(6'b111111, 2, 28'h1200000, 7'b0000000);
    add(6'b101000, 3, 28'h3420000, 7'b0010000);
    add(6'b101100, 5, 28'h3578200, 7'b0010100);
    add(6'b101100, 6, 28'h3579A20, 7'b0010110);
    add(6'b101100, 7, 28'h3579BD2, 7'b0010110);
    add(6'b011100, 1, 28'h2000000, 7'b0010110);
    add(6'b111011, 1, 28'h2000000, 7'b0010110);
    add(6'b100000, 1, 28'h0000000, 7'b0010110);
    // ROM[2]: six misses lose the game.
    add(6'b111111, 2, 28'h1200000, 7'b0000000);
    for (int i = 0; i < 5; i++) add(6'b111010, 7, 28'h3579BD2, 7'b0000000);
    add(6'b111010, 7, 28'h3579BDF, 7'b1000000);
    add(6'b111011, 1, 28'hF000000, 7'b1000000);
    add(6'b100000, 1, 28'h0000000, 7'b0000000);
    // ROM[3] (c r a n e): one hit before the mid-compare reset.
    add(6'b111111, 2, 28'h1200000, 7'b0000000);
    add(6'b100011, 3, 28'h3420000, 7'b0010000);

    #1;
    check("power-up state", 32'(st), 32'd0);
    check("power-up out", 32'(chip_output), 32'd0);

    reset = 1'b1;
    chip_input = 6'b111111;
    tick();
    check("reset hold state", 32'(st), 32'd0);
    check("reset hold out", 32'(chip_output), 32'd0);
    chip_input = '0;
    reset = 1'b0;
    tick();
    check("idle quiet state", 32'(st), 32'd0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Guess n sits in slot 3 of crane, so the walk passes CMP2; reset lands there.
    chip_input = 6'b101110;
    tick();
    chip_input = '0;
    check("walk cmp0", 32'(st), 32'd3);
    tick();
    check("walk cmp1", 32'(st), 32'd5);
    tick();
    check("walk cmp2", 32'(st), 32'd7);
    check("walk out", 32'(chip_output), 32'h10);
    #2;
    reset = 1'b1;
    #1;
    check("async reset state", 32'(st), 32'd0);
    check("async reset out", 32'(chip_output), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post reset state", 32'(st), 32'd0);
    check("post reset out", 32'(chip_output), 32'd0);

    m_mode   = 0;
    m_idx    = 0;
    m_misses = 0;
    for (int k = 0; k < 5; k++) begin
      m_found[k] = 1'b0;
      m_word[k]  = 0;
    end

    for (int it = 0; it < 250; it++) begin
      logic [5:0] d;
      int r;
      r = int'($urandom_range(0, 99));
      case (m_mode)
        0: d = (r < 40) ? 6'b111111 : 6'($urandom);
        2: begin
          if (r < 40)      d = {1'b1, 5'(m_word[$urandom_range(0, 4)])};
          else if (r < 70) d = {1'b1, 5'($urandom_range(1, 26))};
          else if (r < 74) d = 6'b100000;
          else             d = 6'($urandom);
        end
        default: d = (r < 30) ? 6'b100000 : 6'($urandom);
      endcase
      model(d);
      chip_input = d;
      for (int i = 0; i < exp_q.size(); i++) begin
        tick();
        chip_input = '0;
        check($sformatf("rand%0d in%0h state%0d", it, d, i), 32'(st), 32'(exp_q[i]));
      end
      tick();
      check($sformatf("rand%0d out", it), 32'(chip_output), 32'(exp_out()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
